// File: rtl/reg_bank_seq_if.sv
// Host-side streams of reg_bank_seq: instructions in, write data in, read results out.
interface reg_bank_seq_if;
   localparam int unsigned INSTR_W = 24;
   localparam int unsigned WORD_W  = 64;

   logic [INSTR_W-1:0] instr;
   logic               instr_valid;
   logic               instr_ready;
   logic [WORD_W-1:0]  wdata;
   logic               wdata_valid;
   logic               wdata_ready;
   logic [WORD_W-1:0]  rdataA;
   logic [WORD_W-1:0]  rdataB;
   logic               rdata_valid;
   logic               rdata_ready;

   modport master (
      output instr, instr_valid, wdata, wdata_valid, rdata_ready,
      input  instr_ready, wdata_ready, rdataA, rdataB, rdata_valid
   );

   modport slave (
      input  instr, instr_valid, wdata, wdata_valid, rdata_ready,
      output instr_ready, wdata_ready, rdataA, rdataB, rdata_valid
   );
endinterface

// File: rtl/reg_bank_seq.sv
// Instruction sequencer driving a complex-word reg_bank: writes, two-port reads,
// and complex add/subtract with write-back. All outputs are registered.
module reg_bank_seq (
   input  logic                 clock,
   input  logic                 reset,
   reg_bank_seq_if.slave        host,
   output logic                 busy,
   output logic                 regwe,
   output logic [63:0]          inA,
   output logic [3:0]           selwreg,
   output logic [1:0]           endreg,
   output logic [3:0]           seloutA,
   output logic [3:0]           seloutB,
   output logic                 cnstA,
   output logic                 cnstB,
   output logic                 enrregA,
   output logic                 enrregB,
   input  logic [63:0]          outA,
   input  logic [63:0]          outB
);

   localparam int unsigned WORD_W = 64;
   localparam int unsigned HALF_W = 32;
   localparam int unsigned SEL_W  = 4;
   localparam int unsigned END_W  = 2;
   localparam int unsigned RSV_W  = 6;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WDATA,
      S_WAIT1,
      S_CAP,
      S_HOLD
   } state_t;

   typedef enum logic [1:0] {
      OP_WRITE = 2'b00,
      OP_READ  = 2'b01,
      OP_CADD  = 2'b10,
      OP_CSUB  = 2'b11
   } op_t;

   typedef struct packed {
      op_t              op;
      logic [END_W-1:0] endreg;
      logic [SEL_W-1:0] dst;
      logic [SEL_W-1:0] src_a;
      logic [SEL_W-1:0] src_b;
      logic             cnst_a;
      logic             cnst_b;
      logic [RSV_W-1:0] rsvd;
   } instr_t;

   // Sequencer state and latched instruction context
   state_t            state_q,      state_d;
   op_t               op_q,         op_d;
   logic [SEL_W-1:0]  dst_q,        dst_d;
   logic [END_W-1:0]  pend_end_q,   pend_end_d;

   // Registered outputs
   logic              instr_ready_q, instr_ready_d;
   logic              wdata_ready_q, wdata_ready_d;
   logic              rdata_valid_q, rdata_valid_d;
   logic              busy_q,        busy_d;
   logic [WORD_W-1:0] rdata_a_q,     rdata_a_d;
   logic [WORD_W-1:0] rdata_b_q,     rdata_b_d;
   logic              regwe_q,       regwe_d;
   logic [WORD_W-1:0] ina_q,         ina_d;
   logic [SEL_W-1:0]  selwreg_q,     selwreg_d;
   logic [END_W-1:0]  endreg_q,      endreg_d;
   logic [SEL_W-1:0]  selout_a_q,    selout_a_d;
   logic [SEL_W-1:0]  selout_b_q,    selout_b_d;
   logic              cnst_a_q,      cnst_a_d;
   logic              cnst_b_q,      cnst_b_d;
   logic              enrreg_a_q,    enrreg_a_d;
   logic              enrreg_b_q,    enrreg_b_d;

   instr_t            dec;
   logic              instr_fire;
   logic              wdata_fire;
   logic              rdata_fire;
   logic [HALF_W-1:0] re_res;
   logic [HALF_W-1:0] im_res;
   logic              unused_rsvd;

   assign dec         = instr_t'(host.instr);
   assign unused_rsvd = ^dec.rsvd;

   // Ready/valid flags are only ever high in their own state, so they qualify the handshakes
   assign instr_fire = host.instr_valid & instr_ready_q;
   assign wdata_fire = host.wdata_valid & wdata_ready_q;
   assign rdata_fire = host.rdata_ready & rdata_valid_q;

   // Per-half complex add/subtract; the two halves never carry into each other
   always_comb begin
      re_res = outA[WORD_W-1:HALF_W] + outB[WORD_W-1:HALF_W];
      im_res = outA[HALF_W-1:0]      + outB[HALF_W-1:0];
      if (op_q == OP_CSUB) begin
         re_res = outA[WORD_W-1:HALF_W] - outB[WORD_W-1:HALF_W];
         im_res = outA[HALF_W-1:0]      - outB[HALF_W-1:0];
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      dst_d      = dst_q;
      pend_end_d = pend_end_q;
      rdata_a_d  = rdata_a_q;
      rdata_b_d  = rdata_b_q;
      ina_d      = ina_q;
      selwreg_d  = selwreg_q;
      endreg_d   = endreg_q;
      selout_a_d = selout_a_q;
      selout_b_d = selout_b_q;
      regwe_d    = 1'b0;
      cnst_a_d   = 1'b0;
      cnst_b_d   = 1'b0;
      enrreg_a_d = 1'b0;
      enrreg_b_d = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (instr_fire) begin
               op_d       = dec.op;
               dst_d      = dec.dst;
               pend_end_d = dec.endreg;
               if (dec.op == OP_WRITE) begin
                  state_d = S_WDATA;
               end else begin
                  selout_a_d = dec.src_a;
                  selout_b_d = dec.src_b;
                  cnst_a_d   = dec.cnst_a;
                  cnst_b_d   = dec.cnst_b;
                  enrreg_a_d = 1'b1;
                  enrreg_b_d = 1'b1;
                  state_d    = S_WAIT1;
               end
            end
         end

         S_WDATA: begin
            if (wdata_fire) begin
               regwe_d   = 1'b1;
               ina_d     = host.wdata;
               selwreg_d = dst_q;
               endreg_d  = pend_end_q;
               state_d   = S_IDLE;
            end
         end

         // Bank output registers load on the edge leaving this state
         S_WAIT1: begin
            state_d = S_CAP;
         end

         S_CAP: begin
            if (op_q == OP_READ) begin
               rdata_a_d = outA;
               rdata_b_d = outB;
               state_d   = S_HOLD;
            end else begin
               regwe_d   = 1'b1;
               ina_d     = {re_res, im_res};
               selwreg_d = dst_q;
               endreg_d  = pend_end_q;
               state_d   = S_IDLE;
            end
         end

         S_HOLD: begin
            if (rdata_fire) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      instr_ready_d = (state_d == S_IDLE);
      wdata_ready_d = (state_d == S_WDATA);
      rdata_valid_d = (state_d == S_HOLD);
      busy_d        = (state_d != S_IDLE);
   end

   // State and output registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         op_q          <= OP_WRITE;
         dst_q         <= '0;
         pend_end_q    <= '0;
         instr_ready_q <= 1'b0;
         wdata_ready_q <= 1'b0;
         rdata_valid_q <= 1'b0;
         busy_q        <= 1'b0;
         rdata_a_q     <= '0;
         rdata_b_q     <= '0;
         regwe_q       <= 1'b0;
         ina_q         <= '0;
         selwreg_q     <= '0;
         endreg_q      <= '0;
         selout_a_q    <= '0;
         selout_b_q    <= '0;
         cnst_a_q      <= 1'b0;
         cnst_b_q      <= 1'b0;
         enrreg_a_q    <= 1'b0;
         enrreg_b_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         op_q          <= op_d;
         dst_q         <= dst_d;
         pend_end_q    <= pend_end_d;
         instr_ready_q <= instr_ready_d;
         wdata_ready_q <= wdata_ready_d;
         rdata_valid_q <= rdata_valid_d;
         busy_q        <= busy_d;
         rdata_a_q     <= rdata_a_d;
         rdata_b_q     <= rdata_b_d;
         regwe_q       <= regwe_d;
         ina_q         <= ina_d;
         selwreg_q     <= selwreg_d;
         endreg_q      <= endreg_d;
         selout_a_q    <= selout_a_d;
         selout_b_q    <= selout_b_d;
         cnst_a_q      <= cnst_a_d;
         cnst_b_q      <= cnst_b_d;
         enrreg_a_q    <= enrreg_a_d;
         enrreg_b_q    <= enrreg_b_d;
      end
   end

   assign host.instr_ready = instr_ready_q;
   assign host.wdata_ready = wdata_ready_q;
   assign host.rdata_valid = rdata_valid_q;
   assign host.rdataA      = rdata_a_q;
   assign host.rdataB      = rdata_b_q;
   assign busy             = busy_q;
   assign regwe            = regwe_q;
   assign inA              = ina_q;
   assign selwreg          = selwreg_q;
   assign endreg           = endreg_q;
   assign seloutA          = selout_a_q;
   assign seloutB          = selout_b_q;
   assign cnstA            = cnst_a_q;
   assign cnstB            = cnst_b_q;
   assign enrregA          = enrreg_a_q;
   assign enrregB          = enrreg_b_q;

endmodule

// File: tb/tb_reg_bank_seq.sv
// Randomized scoreboard bench for reg_bank_seq with a behavioural register bank
// and a reference model of the complex-word register file.
module tb_reg_bank_seq;

   logic        clock = 1'b0;
   logic        reset;
   logic        busy, regwe, cnstA, cnstB, enrregA, enrregB;
   logic [63:0] inA, outA, outB;
   logic [3:0]  selwreg, seloutA, seloutB;
   logic [1:0]  endreg;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   reg_bank_seq_if host();

   reg_bank_seq dut (
      .clock   (clock),
      .reset   (reset),
      .host    (host),
      .busy    (busy),
      .regwe   (regwe),
      .inA     (inA),
      .selwreg (selwreg),
      .endreg  (endreg),
      .seloutA (seloutA),
      .seloutB (seloutB),
      .cnstA   (cnstA),
      .cnstB   (cnstB),
      .enrregA (enrregA),
      .enrregB (enrregB),
      .outA    (outA),
      .outB    (outB)
   );

   // Behavioural reg_bank: 16 words, registered outputs, constant form on cnst
   logic [63:0] bank [16];

   function automatic logic [63:0] bank_const(input logic [3:0] s);
      return {{31{s[1]}}, s[3], {31{s[0]}}, s[2]};
   endfunction

   always @(posedge clock) begin
      if (regwe) bank[selwreg] <= inA;
      if (enrregA) outA <= cnstA ? bank_const(seloutA) : bank[seloutA];
      if (enrregB) outB <= cnstB ? bank_const(seloutB) : bank[seloutB];
   end

   // Reference model of architectural register contents
   logic [63:0] ref_mem [16];
   logic [69:0]  wr_q [$];
   logic [127:0] rd_q [$];

   function automatic logic [63:0] ref_operand(input logic [3:0] sel, input logic cnst);
      int re;
      int im;
      if (!cnst) return ref_mem[sel];
      re = (sel[1] ? -2 : 0) + int'(sel[3]);
      im = (sel[0] ? -2 : 0) + int'(sel[2]);
      return {32'(re), 32'(im)};
   endfunction

   function automatic logic [63:0] ref_arith(input logic sub, input logic [63:0] a,
                                            input logic [63:0] b);
      int re;
      int im;
      if (sub) begin
         re = int'(a[63:32]) - int'(b[63:32]);
         im = int'(a[31:0])  - int'(b[31:0]);
      end else begin
         re = int'(a[63:32]) + int'(b[63:32]);
         im = int'(a[31:0])  + int'(b[31:0]);
      end
      return {32'(re), 32'(im)};
   endfunction

   function automatic logic [23:0] mk_instr(input logic [1:0] op, input logic [1:0] er,
                                           input logic [3:0] dst, input logic [3:0] sa,
                                           input logic [3:0] sb, input logic ca, input logic cb);
      return {op, er, dst, sa, sb, ca, cb, 6'($urandom)};
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT writes the bank or hands over read data
   initial begin
      logic [69:0]  ew;
      logic [127:0] er;
      forever begin
         @(negedge clock);
         if (regwe) begin
            check("wr_expected", 128'(wr_q.size() != 0), 128'(1));
            if (wr_q.size() != 0) begin
               ew = wr_q.pop_front();
               check("wr_selwreg", 128'(selwreg), 128'(ew[69:66]));
               check("wr_inA",     128'(inA),     128'(ew[65:2]));
               check("wr_endreg",  128'(endreg),  128'(ew[1:0]));
            end
         end
         if (host.rdata_valid && host.rdata_ready) begin
            check("rd_expected", 128'(rd_q.size() != 0), 128'(1));
            if (rd_q.size() != 0) begin
               er = rd_q.pop_front();
               check("rd_data", {host.rdataA, host.rdataB}, er);
            end
         end
      end
   end

   // Called at posedge+1 or at a negedge, so instr_ready already shows the next edge's value
   task automatic send_instr(input logic [23:0] word);
      logic ok;
      ok = 1'b0;
      host.instr       = word;
      host.instr_valid = 1'b1;
      for (int n = 0; n < 20; n++) begin
         if (host.instr_ready) begin
            @(posedge clock);
            #1;
            ok = 1'b1;
            break;
         end
         @(negedge clock);
      end
      host.instr_valid = 1'b0;
      host.instr       = 24'($urandom);
      check("instr_accept", 128'(ok), 128'(1));
   endtask

   task automatic do_write(input logic [3:0] dst, input logic [1:0] er,
                           input logic [63:0] data, input int delay);
      host.wdata_valid = 1'b0;
      wr_q.push_back({dst, data, er});
      ref_mem[dst] = data;
      send_instr(mk_instr(2'b00, er, dst, 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom)));
      host.rdata_ready = 1'($urandom);
      for (int i = 0; i < delay; i++) begin
         @(negedge clock);
         check("wr_wait_flags", 128'({host.instr_ready, host.wdata_ready, regwe, busy}),
               128'(4'b0101));
         @(posedge clock);
         #1;
      end
      host.wdata       = data;
      host.wdata_valid = 1'b1;
      @(negedge clock);
      check("wr_wdata_ready", 128'(host.wdata_ready), 128'(1));
      @(posedge clock);
      #1;
      host.wdata_valid = 1'b0;
      host.wdata       = {$urandom, $urandom};
      host.rdata_ready = 1'b0;
      @(negedge clock);
      check("wr_regwe_pulse", 128'({regwe, host.instr_ready, busy}), 128'(3'b110));
   endtask

   task automatic do_read(input logic [3:0] sa, input logic [3:0] sb,
                          input logic ca, input logic cb, input int hold);
      logic [127:0] exp;
      int n;
      exp = {ref_operand(sa, ca), ref_operand(sb, cb)};
      rd_q.push_back(exp);
      send_instr(mk_instr(2'b01, 2'($urandom), 4'($urandom), sa, sb, ca, cb));
      host.wdata       = {$urandom, $urandom};
      host.wdata_valid = 1'($urandom);
      for (n = 0; n < 10; n++) begin
         @(negedge clock);
         if (host.rdata_valid) break;
      end
      check("rd_latency", 128'(n), 128'(2));
      for (int i = 0; i < hold; i++) begin
         check("rd_hold_flags", 128'({host.rdata_valid, host.instr_ready, busy}), 128'(3'b101));
         check("rd_hold_data", {host.rdataA, host.rdataB}, exp);
         @(negedge clock);
      end
      @(posedge clock);
      #1;
      host.rdata_ready = 1'b1;
      @(negedge clock);
      @(posedge clock);
      #1;
      host.rdata_ready = 1'b0;
      host.wdata_valid = 1'b0;
      @(negedge clock);
      check("rd_release", 128'({host.rdata_valid, host.instr_ready, busy}), 128'(3'b010));
   endtask

   task automatic do_arith(input logic sub, input logic [3:0] dst, input logic [1:0] er,
                           input logic [3:0] sa, input logic [3:0] sb,
                           input logic ca, input logic cb);
      logic [63:0] res;
      int n;
      res = ref_arith(sub, ref_operand(sa, ca), ref_operand(sb, cb));
      wr_q.push_back({dst, res, er});
      ref_mem[dst] = res;
      send_instr(mk_instr(sub ? 2'b11 : 2'b10, er, dst, sa, sb, ca, cb));
      host.wdata       = {$urandom, $urandom};
      host.wdata_valid = 1'($urandom);
      for (n = 0; n < 10; n++) begin
         @(negedge clock);
         if (regwe) break;
      end
      check("arith_latency", 128'(n), 128'(2));
      host.wdata_valid = 1'b0;
   endtask

   task automatic do_mid_reset();
      send_instr(mk_instr(2'b10, 2'b01, 4'd2, 4'd3, 4'd4, 1'b0, 1'b0));
      #2 reset = 1'b0;
      @(negedge clock);
      check("rst_mid_outs", 128'({host.instr_ready, host.wdata_ready, host.rdata_valid, busy,
                                  regwe, inA, selwreg, endreg, seloutA, seloutB,
                                  cnstA, cnstB, enrregA, enrregB}), 128'(0));
      check("rst_mid_rdata", {host.rdataA, host.rdataB}, 128'(0));
      @(posedge clock);
      #1 reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         check("rst_mid_quiet", 128'({regwe, enrregA, enrregB}), 128'(0));
      end
   endtask

   initial begin
      int unsigned kind;
      reset            = 1'b0;
      host.instr       = '0;
      host.instr_valid = 1'b0;
      host.wdata       = '0;
      host.wdata_valid = 1'b0;
      host.rdata_ready = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_outs", 128'({host.instr_ready, host.wdata_ready, host.rdata_valid, busy,
                              regwe, inA, selwreg, endreg, seloutA, seloutB,
                              cnstA, cnstB, enrregA, enrregB}), 128'(0));
      check("rst_rdata", {host.rdataA, host.rdataB}, 128'(0));
      @(posedge clock);
      #1 reset = 1'b1;
      @(negedge clock);
      check("rdy_before_edge", 128'(host.instr_ready), 128'(0));
      @(negedge clock);
      check("rdy_after_edge", 128'(host.instr_ready), 128'(1));

      for (int r = 0; r < 16; r++) do_write(4'(r), 2'($urandom), {$urandom, $urandom}, 0);

      // Directed cases
      do_write(4'd3, 2'b00, 64'h00000005_FFFFFFFF, 0);
      do_read(4'd3, 4'd0, 1'b0, 1'b0, 0);
      do_arith(1'b0, 4'd4, 2'b00, 4'b1000, 4'd3, 1'b1, 1'b0);
      do_read(4'd4, 4'b0110, 1'b0, 1'b1, 1);
      do_write(4'd5, 2'b01, 64'h00000000_00000000, 0);
      do_write(4'd6, 2'b10, 64'h00000001_00000001, 1);
      do_arith(1'b1, 4'd7, 2'b11, 4'd5, 4'd6, 1'b0, 1'b0);
      do_read(4'd7, 4'd6, 1'b0, 1'b0, 0);
      do_write(4'd9, 2'b11, 64'h12345678_9ABCDEF0, 5);
      do_read(4'd9, 4'd7, 1'b0, 1'b0, 4);
      do_mid_reset();
      do_arith(1'b0, 4'd2, 2'b01, 4'd3, 4'd4, 1'b0, 1'b0);
      do_read(4'd2, 4'b1111, 1'b0, 1'b1, 2);

      // Random mix
      for (int k = 0; k < 80; k++) begin
         kind = $urandom_range(3, 0);
         case (kind)
            0: do_write(4'($urandom), 2'($urandom), {$urandom, $urandom}, int'($urandom_range(3, 0)));
            1: do_read(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                       int'($urandom_range(3, 0)));
            2: do_arith(1'b0, 4'($urandom), 2'($urandom), 4'($urandom), 4'($urandom),
                        1'($urandom), 1'($urandom));
            default: do_arith(1'b1, 4'($urandom), 2'($urandom), 4'($urandom), 4'($urandom),
                              1'($urandom), 1'($urandom));
         endcase
      end

      for (int i = 0; i < 10; i++) begin
         if (wr_q.size() == 0 && rd_q.size() == 0) break;
         @(negedge clock);
      end
      check("wr_q_drained", 128'(wr_q.size()), 128'(0));
      check("rd_q_drained", 128'(rd_q.size()), 128'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
